sd_init_sequencer: RTL and testbench



---
 rtl/sd_pkg.sv | 35 +++
 rtl/sd_init_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card SPI-mode initialisation sequencer.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_ISSUE,
        ST_WAIT,
        ST_EVAL,
        ST_READY,
        ST_ERROR
    } state_t;

    // Command indices as sent on the wire (ACMD41 shares index space with CMDs)
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [6:0] CRC_CMD0       = 7'h4A;
    localparam logic [6:0] CRC_CMD8       = 7'h43;
    localparam logic [6:0] CRC_CMD55      = 7'h32;
    localparam logic [6:0] CRC_ACMD41_HCS = 7'h3B;
    localparam logic [6:0] CRC_ACMD41     = 7'h72;
    localparam logic [6:0] CRC_CMD16      = 7'h0A;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CMD0    = 3'd1;
    localparam logic [2:0] ERR_CMD8    = 3'd2;
    localparam logic [2:0] ERR_ACMD41  = 3'd3;
    localparam logic [2:0] ERR_CMD16   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

endpackage

// File: rtl/sd_init_sequencer.sv
// Drives sd_controller through CMD0, CMD8, CMD55/ACMD41 retries and CMD16
// to bring an SD card into SPI-mode ready state.
module sd_init_sequencer
    import sd_pkg::*;
#(
    parameter int MEMORY_SIZE_IN_BYTES = 10,
    parameter int POWERUP_CYCLES       = 80,
    parameter int RETRY_MAX            = 100,
    parameter int DONE_TIMEOUT         = 4096
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    init_start,
    output logic [5:0]                              sd_cmd,
    output logic [31:0]                             sd_arg,
    output logic [6:0]                              sd_crc,
    output logic [$clog2(MEMORY_SIZE_IN_BYTES)-1:0] sd_nresponse,
    output logic                                    sd_start,
    input  logic                                    sd_done,
    input  logic [7:0]                              sd_R1,
    output logic                                    busy,
    output logic                                    ready,
    output logic                                    error,
    output logic [2:0]                              err_code,
    output logic                                    card_v2
);

    localparam int NRESP_W = $clog2(MEMORY_SIZE_IN_BYTES);
    localparam int PWR_W   = $clog2(POWERUP_CYCLES + 1);
    localparam int RETRY_W = $clog2(RETRY_MAX + 1);
    localparam int TMO_W   = $clog2(DONE_TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [5:0]           cur_cmd_q, cur_cmd_d;
    logic [PWR_W-1:0]     pwr_cnt_q, pwr_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [7:0]           r1_q, r1_d;
    logic [2:0]           err_code_q, err_code_d;
    logic                 card_v2_q, card_v2_d;

    logic [31:0]          arg_f;
    logic [6:0]           crc_f;
    logic [NRESP_W-1:0]   nresp_f;
    logic                 fields_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_cmd_q   <= CMD0;
            pwr_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            r1_q        <= '0;
            err_code_q  <= ERR_NONE;
            card_v2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_cmd_q   <= cur_cmd_d;
            pwr_cnt_q   <= pwr_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            r1_q        <= r1_d;
            err_code_q  <= err_code_d;
            card_v2_q   <= card_v2_d;
        end
    end

    // Command field lookup; ACMD41 requests high capacity only on SDv2 cards
    always_comb begin
        arg_f   = 32'h0000_0000;
        crc_f   = CRC_CMD0;
        nresp_f = '0;
        case (cur_cmd_q)
            CMD8: begin
                arg_f   = 32'h0000_01AA;
                crc_f   = CRC_CMD8;
                nresp_f = NRESP_W'(4);
            end
            CMD55:  crc_f = CRC_CMD55;
            ACMD41: begin
                arg_f = card_v2_q ? 32'h4000_0000 : 32'h0000_0000;
                crc_f = card_v2_q ? CRC_ACMD41_HCS : CRC_ACMD41;
            end
            CMD16: begin
                arg_f = 32'h0000_0200;
                crc_f = CRC_CMD16;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_cmd_d   = cur_cmd_q;
        pwr_cnt_d   = pwr_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        r1_d        = r1_q;
        err_code_d  = err_code_q;
        card_v2_d   = card_v2_q;

        case (state_q)
            ST_IDLE, ST_READY, ST_ERROR: begin
                if (init_start) begin
                    state_d     = ST_POWERUP;
                    pwr_cnt_d   = PWR_W'(POWERUP_CYCLES);
                    retry_cnt_d = '0;
                    err_code_d  = ERR_NONE;
                    card_v2_d   = 1'b0;
                end
            end
            ST_POWERUP: begin
                if (pwr_cnt_q == '0) begin
                    cur_cmd_d = CMD0;
                    state_d   = ST_ISSUE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q - PWR_W'(1);
                end
            end
            ST_ISSUE: begin
                // The ISSUE cycle itself counts towards the done timeout
                tmo_cnt_d = TMO_W'(1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (sd_done) begin
                    r1_d    = sd_R1;
                    state_d = ST_EVAL;
                end else if (tmo_cnt_q >= TMO_W'(DONE_TIMEOUT - 1)) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_EVAL: begin
                state_d = ST_ISSUE;
                case (cur_cmd_q)
                    CMD0: begin
                        if (r1_q == 8'h01) begin
                            cur_cmd_d = CMD8;
                        end else begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_CMD0;
                        end
                    end
                    CMD8: begin
                        if (r1_q == 8'h01) begin
                            card_v2_d = 1'b1;
                            cur_cmd_d = CMD55;
                        end else if (r1_q[2]) begin
                            card_v2_d = 1'b0;
                            cur_cmd_d = CMD55;
                        end else begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_CMD8;
                        end
                    end
                    CMD55: begin
                        if (r1_q == 8'h00 || r1_q == 8'h01) begin
                            cur_cmd_d = ACMD41;
                        end else begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_ACMD41;
                        end
                    end
                    ACMD41: begin
                        if (r1_q == 8'h00) begin
                            cur_cmd_d = CMD16;
                        end else if (r1_q == 8'h01) begin
                            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                            if (retry_cnt_q >= RETRY_W'(RETRY_MAX - 1)) begin
                                state_d    = ST_ERROR;
                                err_code_d = ERR_ACMD41;
                            end else begin
                                cur_cmd_d = CMD55;
                            end
                        end else begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_ACMD41;
                        end
                    end
                    CMD16: begin
                        if (r1_q == 8'h00) begin
                            state_d = ST_READY;
                        end else begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_CMD16;
                        end
                    end
                    default: begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_CMD0;
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fields are only presented while a command is in flight, so idle/reset reads as zero
    always_comb begin
        fields_en    = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_EVAL);
        sd_cmd       = fields_en ? cur_cmd_q : 6'd0;
        sd_arg       = fields_en ? arg_f : 32'd0;
        sd_crc       = fields_en ? crc_f : 7'd0;
        sd_nresponse = fields_en ? nresp_f : '0;
        sd_start     = (state_q == ST_ISSUE);
        busy         = fields_en || (state_q == ST_POWERUP);
        ready        = (state_q == ST_READY);
        error        = (state_q == ST_ERROR);
        err_code     = err_code_q;
        card_v2      = card_v2_q;
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Scoreboard bench: expected command fields are queued as each reply is staged
// and compared against the DUT when it raises sd_start.
module tb_sd_init_sequencer;

    localparam int P  = 8;
    localparam int RM = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_start;
    logic [5:0]  sd_cmd;
    logic [31:0] sd_arg;
    logic [6:0]  sd_crc;
    logic [3:0]  sd_nresponse;
    logic        sd_start;
    logic        sd_done;
    logic [7:0]  sd_R1;
    logic        busy;
    logic        ready;
    logic        error;
    logic [2:0]  err_code;
    logic        card_v2;

    sd_init_sequencer #(
        .MEMORY_SIZE_IN_BYTES(10),
        .POWERUP_CYCLES(P),
        .RETRY_MAX(RM),
        .DONE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .init_start(init_start),
        .sd_cmd(sd_cmd), .sd_arg(sd_arg), .sd_crc(sd_crc),
        .sd_nresponse(sd_nresponse), .sd_start(sd_start),
        .sd_done(sd_done), .sd_R1(sd_R1),
        .busy(busy), .ready(ready), .error(error),
        .err_code(err_code), .card_v2(card_v2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic [3:0]  nr;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   start_cnt = 0;

    always @(negedge clk) if (sd_start) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [5:0] c, input logic [31:0] a,
                                input logic [6:0] r, input logic [3:0] n);
        cmd_t t;
        t.cmd = c; t.arg = a; t.crc = r; t.nr = n;
        return t;
    endfunction

    task automatic wait_start(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (sd_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for the next command, compares it, then optionally answers with r1.
    task automatic serve(input cmd_t e, input logic [7:0] r1, input bit reply, output int n);
        bit   ok;
        cmd_t g;
        exp_q.push_back(e);
        wait_start(n, ok);
        g = exp_q.pop_front();
        if (!ok) begin
            chk("start_seen", 32'd0, 32'd1);
            return;
        end
        chk("cmd",   32'(sd_cmd),       32'(g.cmd));
        chk("arg",   sd_arg,            g.arg);
        chk("crc",   32'(sd_crc),       32'(g.crc));
        chk("nresp", 32'(sd_nresponse), 32'(g.nr));
        if (!reply) begin
            $display("txn cmd=%0d arg=%08h no_reply", sd_cmd, sd_arg);
            return;
        end
        // a done raised during the ISSUE cycle must be ignored
        sd_done = 1'b1; sd_R1 = 8'hFF;
        @(negedge clk);
        sd_done = 1'b0;
        chk("start_one_cycle", 32'(sd_start), 32'd0);
        repeat (2) @(negedge clk);
        sd_done = 1'b1; sd_R1 = r1;
        @(negedge clk);
        sd_done = 1'b0;
        chk("eval_cmd_stable", 32'(sd_cmd), 32'(g.cmd));
        chk("eval_busy", 32'(busy), 32'd1);
        $display("txn cmd=%0d arg=%08h crc=%02h r1=%02h", g.cmd, g.arg, g.crc, r1);
    endtask

    task automatic start_seq();
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        chk("start_busy",    32'(busy),     32'd1);
        chk("start_ready",   32'(ready),    32'd0);
        chk("start_error",   32'(error),    32'd0);
        chk("start_errcode", 32'(err_code), 32'd0);
        chk("start_v2",      32'(card_v2),  32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd"},   32'(sd_cmd),       32'd0);
        chk({tag, "_arg"},   sd_arg,            32'd0);
        chk({tag, "_crc"},   32'(sd_crc),       32'd0);
        chk({tag, "_nr"},    32'(sd_nresponse), 32'd0);
        chk({tag, "_start"}, 32'(sd_start),     32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_ready"}, 32'(ready),        32'd0);
        chk({tag, "_error"}, 32'(error),        32'd0);
        chk({tag, "_code"},  32'(err_code),     32'd0);
        chk({tag, "_v2"},    32'(card_v2),      32'd0);
    endtask

    task automatic expect_final(input string tag, input logic rdy, input logic err,
                                input logic [2:0] code, input logic v2);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ready),    32'(rdy));
        chk({tag, "_error"}, 32'(error),    32'(err));
        chk({tag, "_code"},  32'(err_code), 32'(code));
        chk({tag, "_v2"},    32'(card_v2),  32'(v2));
        chk({tag, "_busy"},  32'(busy),     32'd0);
    endtask

    cmd_t C0, C8, C55, A41_V2, A41_V1, C16;

    initial begin
        int n;
        int s0;
        C0     = mk(6'd0,  32'h0,        7'h4A, 4'd0);
        C8     = mk(6'd8,  32'h0000_01AA, 7'h43, 4'd4);
        C55    = mk(6'd55, 32'h0,        7'h32, 4'd0);
        A41_V2 = mk(6'd41, 32'h4000_0000, 7'h3B, 4'd0);
        A41_V1 = mk(6'd41, 32'h0,        7'h72, 4'd0);
        C16    = mk(6'd16, 32'h0000_0200, 7'h0A, 4'd0);

        rst = 1'b1; init_start = 1'b0; sd_done = 1'b0; sd_R1 = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // SDv2 card, one ACMD41 retry
        start_seq();
        s0 = start_cnt;
        serve(C0, 8'h01, 1'b1, n);      chk("powerup_latency", 32'(n), 32'(P + 1));
        serve(C8, 8'h01, 1'b1, n);      chk("issue_after_eval", 32'(n), 32'd1);
        serve(C55, 8'h01, 1'b1, n);
        serve(A41_V2, 8'h01, 1'b1, n);
        serve(C55, 8'h01, 1'b1, n);
        serve(A41_V2, 8'h00, 1'b1, n);  chk("issue_after_eval2", 32'(n), 32'd1);
        serve(C16, 8'h00, 1'b1, n);
        expect_final("v2", 1'b1, 1'b0, 3'd0, 1'b1);
        repeat (5) @(negedge clk);
        chk("v2_ready_sticky", 32'(ready), 32'd1);
        chk("v2_start_count", 32'(start_cnt - s0), 32'd7);

        // SDv1 card: CMD8 illegal-command reply
        start_seq();
        serve(C0, 8'h01, 1'b1, n);
        serve(C8, 8'h05, 1'b1, n);
        serve(C55, 8'h01, 1'b1, n);
        serve(A41_V1, 8'h00, 1'b1, n);
        serve(C16, 8'h00, 1'b1, n);
        expect_final("v1", 1'b1, 1'b0, 3'd0, 1'b0);

        // CMD0 rejected
        start_seq();
        s0 = start_cnt;
        serve(C0, 8'hFF, 1'b1, n);
        expect_final("cmd0err", 1'b0, 1'b1, 3'd1, 1'b0);
        repeat (20) @(negedge clk);
        chk("cmd0err_start_count", 32'(start_cnt - s0), 32'd1);
        chk("cmd0err_sticky", 32'(error), 32'd1);

        // ACMD41 never leaves idle: RETRY_MAX pairs then give up
        start_seq();
        s0 = start_cnt;
        serve(C0, 8'h01, 1'b1, n);
        serve(C8, 8'h01, 1'b1, n);
        for (int i = 0; i < RM; i++) begin
            serve(C55, 8'h01, 1'b1, n);
            serve(A41_V2, 8'h01, 1'b1, n);
        end
        expect_final("retry", 1'b0, 1'b1, 3'd3, 1'b1);
        repeat (5) @(negedge clk);
        chk("retry_start_count", 32'(start_cnt - s0), 32'(2 + 2 * RM));

        // sd_done never arrives
        start_seq();
        serve(C0, 8'h00, 1'b0, n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (error) break;
        end
        chk("timeout_latency", 32'(n), 32'(TO));
        chk("timeout_code", 32'(err_code), 32'd5);

        // reset during CMD55 WAIT, then a clean restart
        start_seq();
        serve(C0, 8'h01, 1'b1, n);
        serve(C8, 8'h01, 1'b1, n);
        serve(C55, 8'h00, 1'b0, n);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        s0 = start_cnt;
        sd_done = 1'b1; sd_R1 = 8'h00;
        @(negedge clk);
        sd_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_done_busy", 32'(busy), 32'd0);
        chk("late_done_start", 32'(start_cnt - s0), 32'd0);
        start_seq();
        serve(C0, 8'h01, 1'b1, n);      chk("restart_latency", 32'(n), 32'(P + 1));
        serve(C8, 8'h01, 1'b1, n);
        serve(C55, 8'h01, 1'b1, n);
        serve(A41_V2, 8'h00, 1'b1, n);
        serve(C16, 8'h00, 1'b1, n);
        expect_final("restart", 1'b1, 1'b0, 3'd0, 1'b1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
